// File: rtl/inst_buffer.sv
// rtl/inst_buffer.sv - ID-stage instruction buffer: captures IF fetches, splits 64-bit SRAM words, issues one instruction per cycle
module inst_buffer #(
  parameter int DEPTH    = 16,
  parameter int AW       = $clog2(DEPTH),
  parameter int STALL_TH = 6
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          flush,
  input  logic          stall_id,
  input  logic [33:0]   if_to_id_bus,
  input  logic [63:0]   inst_sram_rdata,
  output logic          fifo_stall_req,
  output logic          id_valid,
  output logic [31:0]   id_pc,
  output logic [31:0]   id_inst,
  output logic [AW:0]   fifo_count,
  output logic          overflow_err
);

  typedef struct packed {
    logic        discard;
    logic        ce;
    logic [31:0] pc;
  } req_t;

  req_t          req_q, req_d;
  logic [AW-1:0] rptr_q, rptr_d;
  logic [AW-1:0] wptr_q, wptr_d;
  logic [AW:0]   count_q, count_d;
  logic          ovf_q, ovf_d;
  logic [31:0]   mem_pc_q   [DEPTH];
  logic [31:0]   mem_pc_d   [DEPTH];
  logic [31:0]   mem_inst_q [DEPTH];
  logic [31:0]   mem_inst_d [DEPTH];

  logic          pop;
  logic          push_req;
  logic          push_two;
  logic          push;
  logic          fits;
  logic [1:0]    push_n;
  logic [1:0]    push_cnt;
  logic [AW+1:0] free;
  logic [AW-1:0] wptr_nx;
  logic [AW:0]   space;

  assign id_valid = (count_q != '0) & ~flush;
  assign pop      = id_valid & ~stall_id;

  // The request captured last cycle is what the SRAM data now belongs to.
  assign push_req = req_q.ce & ~req_q.discard & ~flush;
  assign push_two = ~req_q.pc[2];
  assign push_n   = push_two ? 2'd2 : 2'd1;
  assign free     = (AW+2)'(DEPTH) - (AW+2)'(count_q) + (AW+2)'(pop);
  assign fits     = free >= (AW+2)'(push_n);
  assign push     = push_req & fits;
  assign push_cnt = push ? push_n : 2'd0;
  assign wptr_nx  = wptr_q + AW'(1);

  always_comb begin
    req_d      = if_to_id_bus;
    rptr_d     = rptr_q;
    wptr_d     = wptr_q;
    count_d    = count_q;
    ovf_d      = ovf_q | (push_req & ~fits);
    mem_pc_d   = mem_pc_q;
    mem_inst_d = mem_inst_q;

    if (push) begin
      mem_pc_d[wptr_q]   = req_q.pc;
      mem_inst_d[wptr_q] = push_two ? inst_sram_rdata[31:0] : inst_sram_rdata[63:32];
      if (push_two) begin
        mem_pc_d[wptr_nx]   = req_q.pc + 32'd4;
        mem_inst_d[wptr_nx] = inst_sram_rdata[63:32];
      end
      wptr_d = wptr_q + AW'(push_cnt);
    end
    if (pop) begin
      rptr_d = rptr_q + AW'(1);
    end
    count_d = count_q + (AW+1)'(push_cnt) - (AW+1)'(pop);

    if (flush) begin
      req_d   = '0;
      rptr_d  = '0;
      wptr_d  = '0;
      count_d = '0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      req_q   <= '0;
      rptr_q  <= '0;
      wptr_q  <= '0;
      count_q <= '0;
      ovf_q   <= 1'b0;
    end else begin
      req_q   <= req_d;
      rptr_q  <= rptr_d;
      wptr_q  <= wptr_d;
      count_q <= count_d;
      ovf_q   <= ovf_d;
    end
  end

  // Storage needs no reset: entries are only visible through count_q.
  always_ff @(posedge clk) begin
    mem_pc_q   <= mem_pc_d;
    mem_inst_q <= mem_inst_d;
  end

  assign id_pc        = id_valid ? mem_pc_q[rptr_q]   : 32'd0;
  assign id_inst      = id_valid ? mem_inst_q[rptr_q] : 32'd0;
  assign fifo_count   = count_q;
  assign overflow_err = ovf_q;

  assign space          = (AW+1)'(DEPTH) - count_q;
  assign fifo_stall_req = ~rst & (space <= (AW+1)'(STALL_TH));

endmodule

// File: tb/tb_inst_buffer.sv
// tb/tb_inst_buffer.sv - randomized self-checking bench for inst_buffer against a queue model
module tb_inst_buffer;
  localparam int DEPTH    = 16;
  localparam int AW       = 4;
  localparam int STALL_TH = 6;

  logic          clk = 1'b0;
  logic          rst;
  logic          flush;
  logic          stall_id;
  logic [33:0]   if_to_id_bus;
  logic [63:0]   inst_sram_rdata;
  logic          fifo_stall_req;
  logic          id_valid;
  logic [31:0]   id_pc;
  logic [31:0]   id_inst;
  logic [AW:0]   fifo_count;
  logic          overflow_err;

  inst_buffer #(.DEPTH(DEPTH), .AW(AW), .STALL_TH(STALL_TH)) dut (
    .clk            (clk),
    .rst            (rst),
    .flush          (flush),
    .stall_id       (stall_id),
    .if_to_id_bus   (if_to_id_bus),
    .inst_sram_rdata(inst_sram_rdata),
    .fifo_stall_req (fifo_stall_req),
    .id_valid       (id_valid),
    .id_pc          (id_pc),
    .id_inst        (id_inst),
    .fifo_count     (fifo_count),
    .overflow_err   (overflow_err)
  );

  always #5 clk = ~clk;

  int        n_checks = 0;
  int        n_errors = 0;
  bit [63:0] mq[$];
  bit        m_ovf = 1'b0;
  bit [33:0] m_req = '0;
  bit        model_live = 1'b0;
  bit        stall_prev = 1'b0;
  bit [31:0] fpc;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // Reference model: a queue of {pc, inst}; push sizes and space follow the fetch rules directly.
  task automatic cycle();
    bit [63:0] head;
    bit        ev;
    bit        es;
    bit        pop;
    bit        do_push;
    int        n;
    int        fr;
    #1;
    ev   = (mq.size() != 0) && !flush;
    head = ev ? mq[0] : 64'd0;
    es   = !rst && ((DEPTH - mq.size()) <= STALL_TH);
    if (model_live) begin
      check_eq("id_valid", 64'(id_valid), 64'(ev));
      check_eq("id_pc", 64'(id_pc), 64'(head[63:32]));
      check_eq("id_inst", 64'(id_inst), 64'(head[31:0]));
      check_eq("fifo_count", 64'(fifo_count), 64'(mq.size()));
      check_eq("fifo_stall_req", 64'(fifo_stall_req), 64'(es));
      check_eq("overflow_err", 64'(overflow_err), 64'(m_ovf));
    end
    stall_prev = es;
    @(posedge clk);
    if (rst) begin
      mq.delete();
      m_ovf = 1'b0;
      m_req = '0;
      model_live = 1'b1;
    end else if (flush) begin
      mq.delete();
      m_req = '0;
    end else begin
      pop     = (mq.size() != 0) && !stall_id;
      do_push = 1'b0;
      n       = m_req[2] ? 1 : 2;
      if (m_req[32] && !m_req[33]) begin
        fr = DEPTH - mq.size() + (pop ? 1 : 0);
        if (fr < n) m_ovf = 1'b1;
        else do_push = 1'b1;
      end
      if (pop) void'(mq.pop_front());
      if (do_push) begin
        if (n == 1) begin
          mq.push_back({m_req[31:0], inst_sram_rdata[63:32]});
        end else begin
          mq.push_back({m_req[31:0], inst_sram_rdata[31:0]});
          mq.push_back({m_req[31:0] + 32'd4, inst_sram_rdata[63:32]});
        end
      end
      m_req = if_to_id_bus;
    end
    #1;
  endtask

  initial begin
    rst = 1'b1; flush = 1'b0; stall_id = 1'b0; if_to_id_bus = '0; inst_sram_rdata = '0;
    cycle(); cycle();
    rst = 1'b0;

    // basic fetch
    if_to_id_bus = {2'b01, 32'hbfc00000}; cycle();
    if_to_id_bus = '0; inst_sram_rdata = {32'h24020002, 32'h24010001}; cycle();
    inst_sram_rdata = '0;
    check_eq("basic_pc0", 64'(id_pc), 64'h0bfc00000);
    check_eq("basic_inst0", 64'(id_inst), 64'h24010001);
    check_eq("basic_cnt2", 64'(fifo_count), 64'd2);
    cycle();
    check_eq("basic_pc1", 64'(id_pc), 64'h0bfc00004);
    check_eq("basic_inst1", 64'(id_inst), 64'h24020002);
    cycle();
    check_eq("basic_cnt0", 64'(fifo_count), 64'd0);

    // discarded packet followed by a live one
    if_to_id_bus = {2'b11, 32'hbfc00008}; inst_sram_rdata = {$urandom, $urandom}; cycle();
    if_to_id_bus = {2'b01, 32'hbfc00100}; inst_sram_rdata = {$urandom, $urandom}; cycle();
    if_to_id_bus = '0; inst_sram_rdata = {$urandom, $urandom}; cycle();
    check_eq("discard_pc", 64'(id_pc), 64'h0bfc00100);
    repeat (3) cycle();

    // unaligned target
    if_to_id_bus = {2'b01, 32'hbfc00104}; cycle();
    if_to_id_bus = '0; inst_sram_rdata = {32'hdeadbeef, 32'h0badf00d}; cycle();
    check_eq("unal_pc", 64'(id_pc), 64'h0bfc00104);
    check_eq("unal_inst", 64'(id_inst), 64'hdeadbeef);
    check_eq("unal_cnt", 64'(fifo_count), 64'd1);
    cycle();

    // backpressure with IF honouring the stall request
    stall_id = 1'b1; fpc = 32'hbfc00200;
    repeat (40) begin
      if_to_id_bus = {1'b0, !stall_prev, fpc};
      if (!stall_prev) fpc += 32'd8;
      inst_sram_rdata = {$urandom, $urandom}; cycle();
    end
    check_eq("bp_no_ovf", 64'(overflow_err), 64'd0);
    stall_id = 1'b0;
    repeat (40) begin
      if_to_id_bus = {1'b0, !stall_prev, fpc};
      if (!stall_prev) fpc += 32'd8;
      inst_sram_rdata = {$urandom, $urandom}; cycle();
    end
    if_to_id_bus = '0;
    repeat (20) cycle();

    // flush with 5 entries held and a push pending
    stall_id = 1'b1;
    if_to_id_bus = {2'b01, 32'hbfc00300}; inst_sram_rdata = {$urandom, $urandom}; cycle();
    if_to_id_bus = {2'b01, 32'hbfc00308}; inst_sram_rdata = {$urandom, $urandom}; cycle();
    if_to_id_bus = {2'b01, 32'hbfc00314}; inst_sram_rdata = {$urandom, $urandom}; cycle();
    if_to_id_bus = '0; inst_sram_rdata = {$urandom, $urandom}; cycle();
    if_to_id_bus = {2'b01, 32'hbfc00400}; cycle();
    check_eq("fl_cnt5", 64'(fifo_count), 64'd5);
    if_to_id_bus = '0; flush = 1'b1; inst_sram_rdata = {$urandom, $urandom};
    #1 check_eq("fl_valid", 64'(id_valid), 64'd0);
    cycle();
    flush = 1'b0;
    check_eq("fl_cnt0", 64'(fifo_count), 64'd0);
    stall_id = 1'b0;
    repeat (3) cycle();

    // forced overflow, IF ignoring the stall request
    stall_id = 1'b1;
    if_to_id_bus = {2'b01, 32'hbfc00504}; inst_sram_rdata = {$urandom, $urandom}; cycle();
    fpc = 32'hbfc00508;
    repeat (10) begin
      if_to_id_bus = {2'b01, fpc}; fpc += 32'd8;
      inst_sram_rdata = {$urandom, $urandom}; cycle();
    end
    if_to_id_bus = '0; cycle();
    check_eq("ovf_cnt15", 64'(fifo_count), 64'd15);
    check_eq("ovf_set", 64'(overflow_err), 64'd1);
    flush = 1'b1; cycle(); flush = 1'b0; stall_id = 1'b0;
    cycle();
    check_eq("ovf_sticky", 64'(overflow_err), 64'd1);

    // randomized traffic
    for (int i = 0; i < 1200; i++) begin
      bit honor;
      bit ce;
      honor    = (i / 300) % 2 == 0;
      stall_id = ($urandom_range(0, 3) == 0);
      flush    = ($urandom_range(0, 50) == 0);
      rst      = ($urandom_range(0, 200) == 0);
      ce       = ($urandom_range(0, 3) != 0) && (!honor || !stall_prev);
      if_to_id_bus    = {($urandom_range(0, 5) == 0), ce, $urandom() & 32'hfffffffc};
      inst_sram_rdata = {$urandom, $urandom};
      cycle();
    end

    flush = 1'b0; stall_id = 1'b0; if_to_id_bus = '0;
    rst = 1'b1; cycle(); rst = 1'b0;
    check_eq("rst_ovf", 64'(overflow_err), 64'd0);
    check_eq("rst_cnt", 64'(fifo_count), 64'd0);
    cycle();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end
endmodule

// File: doc/inst_buffer.md
# inst_buffer

Instruction buffer at the head of ID, on the receiving end of the IF fetch interface. It captures each fetch request from IF and, one cycle later, writes the returned 64-bit instruction-SRAM word into a circular FIFO as two 32-bit instructions with their PCs. Packets that IF marks as discarded are dropped. The buffer issues one instruction per cycle to the decoder and asks IF to stop fetching when space runs low.

## Interface
- DEPTH, 16: number of entries; a power of two, at least 8.
- AW, log2(DEPTH): pointer width.
- STALL_TH, 6: `fifo_stall_req` asserts when free entries ≤ STALL_TH.

- clk  in  1  clock, rising edge.
- rst  in  1  reset, synchronous, active-high.
- flush  in  1  pipeline flush (exception/eret); empties the buffer.
- stall_id  in  1  decoder cannot accept an instruction this cycle.
- if_to_id_bus  in  34  {discard[33], ce[32], pc[31:0]} from IF; describes the SRAM request issued this cycle.
- inst_sram_rdata  in  64  SRAM read data, one cycle after the request; [31:0] is the word at pc, [63:32] is the word at pc+4.
- fifo_stall_req  out  1  request to stall IF (feeds stall[0]).
- id_valid  out  1  head entry valid.
- id_pc  out  32  PC of the head entry.
- id_inst  out  32  instruction of the head entry.
- fifo_count  out  AW+1  occupied entries.
- overflow_err  out  1  sticky; a push was attempted with insufficient space.

## Operation
- Request register req_q: {discard, ce, pc}, loaded from if_to_id_bus every cycle.
  - Loaded with ce=0 on rst or flush.
- Push, in the cycle after capture, when req_q.ce=1, req_q.discard=0 and flush=0:
  - pc[2]=0: push two entries, {pc, rdata[31:0]} then {pc+4, rdata[63:32]}, written at wptr and wptr+1 (mod DEPTH).
  - pc[2]=1: push one entry, {pc, rdata[63:32]}.
  - req_q.discard=1: no entries written, and rdata is ignored.
- Pop when id_valid=1 and stall_id=0: rptr advances by 1 (mod DEPTH).
- Counting: fifo_count next = count + pushed − popped. Push and pop in the same cycle are both honoured.
- Space check uses free = DEPTH − count + popped-this-cycle.
  - If free is less than the push size, the whole push is dropped and overflow_err is set.
  - overflow_err clears only on rst.
- Outputs are show-ahead (fall-through):
  - id_valid = (count≠0) & ~flush.
  - id_pc and id_inst are read combinationally from the entry at rptr.
  - When id_valid=0, id_pc and id_inst are 0.
- fifo_stall_req = (DEPTH − count) ≤ STALL_TH, computed combinationally from the count register. It is 0 while rst is high.
- flush takes priority over every other action:
  - next cycle: count=0, rptr=wptr=0, req_q.ce=0;
  - that cycle's push and pop are suppressed.
- Pointer wrap: pointers are AW bits wide and wrap naturally. A two-entry push may straddle index DEPTH−1 → 0.

## Timing
- Reset values (cycle after rst is sampled high):
  - count=0, rptr=wptr=0, req_q=0, overflow_err=0;
  - therefore id_valid=0, id_pc=0, id_inst=0, fifo_count=0, fifo_stall_req=0.
- Latency:
  - request at cycle t → data written at the edge ending t+1 → id_valid at t+2 (buffer previously empty).
  - Minimum fetch-to-issue is 2 cycles.
- Flow control: with STALL_TH=6, IF honouring fifo_stall_req (its ce drops one cycle later) never causes overflow.
- Empty and push in the same cycle: the entry is not visible until the next cycle (no same-cycle bypass).
- Full and pop in the same cycle: the popped slot counts as free for that cycle's push.
- rst during operation: everything returns to reset values; an in-flight SRAM response is ignored.

## Test plan
- Basic fetch: reset, then ce=1, pc=0xbfc00000, with rdata={0x24020002,0x24010001} the next cycle → at t+2 id_pc=0xbfc00000/id_inst=0x24010001, then 0xbfc00004/0x24020002; fifo_count goes 2→1→0.
- Discard: packet pc=0xbfc00008 with discard=1, followed by pc=0xbfc00100 with discard=0 → only 0xbfc00100 and 0xbfc00104 are ever issued.
- Unaligned target: pc=0xbfc00104 (pc[2]=1), rdata[63:32]=0xdeadbeef → exactly one entry, id_pc=0xbfc00104, id_inst=0xdeadbeef.
- Backpressure: stall_id=1 held while IF streams ce=1 and obeys fifo_stall_req → fifo_stall_req rises at count=10 (DEPTH=16), count peaks ≤16, overflow_err stays 0; on release, instructions drain in PC order, including across the wrap.
- Forced overflow: hold stall_id=1, ignore fifo_stall_req, keep ce=1 → the push at count=15 is dropped, overflow_err=1 and stays 1, count remains 15.
- Flush: buffer holding 5 entries, flush=1 in the same cycle as a pending push → id_valid=0 that cycle, next cycle count=0, and the pending packet is never issued.
